// File: rtl/thor2022_seqnum_alloc.sv
// Reorder-buffer sequence-number allocator: program-order sns per bucket, retire renumbering, flush stomp.
// Optional protocol checker enabled by defining THOR_SEQNUM_CHECK_EN.
module thor2022_seqnum_alloc #(
  parameter int REB_ENTRIES = 6,
  parameter int SNW         = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc0_v,
  input  logic [2:0]                  alloc0_slot,
  input  logic                        alloc1_v,
  input  logic [2:0]                  alloc1_slot,
  input  logic                        retire0_v,
  input  logic [2:0]                  retire0_slot,
  input  logic                        retire1_v,
  input  logic [2:0]                  retire1_slot,
  input  logic                        flush_v,
  input  logic [2:0]                  flush_slot,
  output logic [7:0][SNW-1:0]         sns,
  output logic [REB_ENTRIES-1:0]      live,
  output logic [7:0]                  stomp,
  output logic [2:0]                  count,
  output logic                        full,
  output logic                        busy,
  output logic                        err
);

  localparam logic [SNW-1:0] NONE = '1;
  localparam logic [2:0]     NENT = 3'(REB_ENTRIES);

  typedef enum logic {IDLE, STOMP} state_t;

  state_t         state, state_n;
  logic [SNW-1:0] sq [8];
  logic [SNW-1:0] sq_n [8];
  logic [SNW-1:0] sr [8];
  logic [7:0]     live_q, live_n, lr;
  logic [7:0]     stomp_q, stomp_n;
  logic [2:0]     cnt_q, cnt_n, cr;
  logic           ret0, ret1;
  logic [1:0]     nret;
  logic           flush_ok, a0_ok, a1_ok;
  logic [SNW-1:0] fsn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = IDLE;
    if (state == IDLE && flush_ok) state_n = STOMP;
  end

  always_comb begin
    busy = (state == STOMP);
  end

  // Retire renumbers first; flush and alloc then see the post-retire view.
  always_comb begin
    ret0 = retire0_v;
    ret1 = retire0_v & retire1_v;
    nret = {1'b0, ret0} + {1'b0, ret1};
    sr   = sq;
    lr   = live_q;
    for (int i = 0; i < REB_ENTRIES; i++) begin
      if (live_q[i]) begin
        if ((ret0 && retire0_slot == 3'(i)) ||
            (ret1 && retire1_slot == 3'(i))) begin
          sr[i] = NONE;
          lr[i] = 1'b0;
        end else begin
          sr[i] = sq[i] - SNW'(nret);
        end
      end
    end
    cr = cnt_q - {1'b0, nret};
  end

  always_comb begin
    sq_n     = sr;
    live_n   = lr;
    cnt_n    = cr;
    stomp_n  = '0;
    a0_ok    = 1'b0;
    a1_ok    = 1'b0;
    fsn      = sr[flush_slot];
    flush_ok = (state == IDLE) && flush_v && lr[flush_slot];
    if (flush_ok) begin
      for (int i = 0; i < REB_ENTRIES; i++) begin
        if (lr[i] && sr[i] > fsn) begin
          stomp_n[i] = 1'b1;
          sq_n[i]    = NONE;
          live_n[i]  = 1'b0;
        end
      end
      cnt_n = fsn[2:0] + 3'd1;
    end else if (state == IDLE) begin
      a0_ok = alloc0_v && alloc0_slot < NENT &&
              !live_n[alloc0_slot] && cnt_n < NENT;
      if (a0_ok) begin
        sq_n[alloc0_slot]   = SNW'(cnt_n);
        live_n[alloc0_slot] = 1'b1;
        cnt_n               = cnt_n + 3'd1;
      end
      a1_ok = alloc0_v && alloc1_v && alloc1_slot < NENT &&
              !live_n[alloc1_slot] && cnt_n < NENT;
      if (a1_ok) begin
        sq_n[alloc1_slot]   = SNW'(cnt_n);
        live_n[alloc1_slot] = 1'b1;
        cnt_n               = cnt_n + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) sq[i] <= NONE;
      live_q  <= '0;
      stomp_q <= '0;
      cnt_q   <= '0;
    end else begin
      sq      <= sq_n;
      live_q  <= live_n;
      stomp_q <= stomp_n;
      cnt_q   <= cnt_n;
    end
  end

`ifdef THOR_SEQNUM_CHECK_EN
  logic err_q, viol;
  logic a1_full;

  always_comb begin
    a1_full = (cr + {2'b0, a0_ok}) >= NENT;
    viol = (retire0_v && sq[retire0_slot] != '0) ||
           (ret1 && sq[retire1_slot] != SNW'(1)) ||
           (retire1_v && !retire0_v) ||
           (alloc1_v && !alloc0_v) ||
           (flush_v && (state == STOMP || !lr[flush_slot])) ||
           (state == IDLE && !flush_ok && alloc0_v &&
            (lr[alloc0_slot] || cr == NENT)) ||
           (state == IDLE && !flush_ok && alloc0_v && alloc1_v &&
            (lr[alloc1_slot] || a1_full));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | viol;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) sns[i] = (i < REB_ENTRIES) ? sq[i] : NONE;
  end

  assign live  = live_q[REB_ENTRIES-1:0];
  assign stomp = stomp_q;
  assign count = cnt_q;
  assign full  = (cnt_q == NENT);

endmodule

// File: tb/tb_thor2022_seqnum_alloc.sv
// Bench for thor2022_seqnum_alloc: directed scenarios plus random traffic
// against a program-order queue model.
module tb_thor2022_seqnum_alloc;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc0_v, alloc1_v, retire0_v, retire1_v, flush_v;
  logic [2:0]      alloc0_slot, alloc1_slot, retire0_slot, retire1_slot, flush_slot;
  logic [7:0][5:0] sns;
  logic [5:0]      live;
  logic [7:0]      stomp;
  logic [2:0]      count;
  logic            full, busy, err;

  int ntests = 0;
  int nfail  = 0;

  // Model: slots in program order; a slot's sns is its queue position.
  int         q[$];
  bit         busy_m;
  logic [7:0] stomp_m;

  thor2022_seqnum_alloc dut (
    .clk(clk), .rst(rst),
    .alloc0_v(alloc0_v), .alloc0_slot(alloc0_slot),
    .alloc1_v(alloc1_v), .alloc1_slot(alloc1_slot),
    .retire0_v(retire0_v), .retire0_slot(retire0_slot),
    .retire1_v(retire1_v), .retire1_slot(retire1_slot),
    .flush_v(flush_v), .flush_slot(flush_slot),
    .sns(sns), .live(live), .stomp(stomp), .count(count),
    .full(full), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int find(int s);
    for (int i = 0; i < q.size(); i++) if (q[i] == s) return i;
    return -1;
  endfunction

  function automatic void try_push(int s);
    if (s < 6 && find(s) < 0 && q.size() < 6) q.push_back(s);
  endfunction

  function automatic void model_step(bit a0v, int a0s, bit a1v, int a1s,
                                     bit r0v, bit r1v, bit fv, int fs);
    int n, idx;
    bit fl;
    n = r0v ? (r1v ? 2 : 1) : 0;
    repeat (n) if (q.size() > 0) void'(q.pop_front());
    stomp_m = '0;
    fl = 0;
    if (!busy_m && fv) begin
      idx = find(fs);
      if (idx >= 0) begin
        while (q.size() > idx + 1) begin
          stomp_m[q[q.size()-1]] = 1'b1;
          void'(q.pop_back());
        end
        fl = 1;
      end
    end
    if (!busy_m && !fl && a0v) begin
      try_push(a0s);
      if (a1v) try_push(a1s);
    end
    busy_m = fl;
  endfunction

  task automatic clear_inputs();
    alloc0_v = 0; alloc0_slot = 0; alloc1_v = 0; alloc1_slot = 0;
    retire0_v = 0; retire0_slot = 0; retire1_v = 0; retire1_slot = 0;
    flush_v = 0; flush_slot = 0;
  endtask

  task automatic cycle(bit a0v, int a0s, bit a1v, int a1s,
                       bit r0v, int r0s, bit r1v, int r1s, bit fv, int fs);
    alloc0_v = a0v; alloc0_slot = 3'(a0s);
    alloc1_v = a1v; alloc1_slot = 3'(a1s);
    retire0_v = r0v; retire0_slot = 3'(r0s);
    retire1_v = r1v; retire1_slot = 3'(r1s);
    flush_v = fv; flush_slot = 3'(fs);
    model_step(a0v, a0s, a1v, a1s, r0v, r1v, fv, fs);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    busy_m = 0;
    stomp_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill6();
    cycle(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 2, 1, 3, 0, 0, 0, 0, 0, 0);
    cycle(1, 4, 1, 5, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    ntests++;
    if (sns !== {8{6'h3F}} || live !== 6'd0 || stomp !== 8'd0 ||
        count !== 3'd0 || full !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      nfail++;
      $display("FAIL reset: sns=%h live=%b stomp=%h count=%0d full=%b busy=%b err=%b, want all-3F/0",
               sns, live, stomp, count, full, busy, err);
    end
  endtask

  task automatic test_alloc();
    logic [7:0][5:0] exp;
    do_reset();
    cycle(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 2, 1, 3, 0, 0, 0, 0, 0, 0);
    exp = {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'd3, 6'd2, 6'd1, 6'd0};
    ntests++;
    if (sns !== exp || count !== 3'd4 || live !== 6'b001111) begin
      nfail++;
      $display("FAIL alloc: sns=%h count=%0d live=%b, want sns=%h count=4 live=001111",
               sns, count, live, exp);
    end
  endtask

  task automatic test_retire_alloc();
    cycle(1, 4, 0, 0, 1, 0, 1, 1, 0, 0);
    ntests++;
    if (sns[2] !== 6'd0 || sns[3] !== 6'd1 || sns[4] !== 6'd2 ||
        sns[0] !== 6'h3F || sns[1] !== 6'h3F || count !== 3'd3) begin
      nfail++;
      $display("FAIL retire_alloc: sns=%h count=%0d, want slots2..4=0,1,2 slots0,1=3F count=3",
               sns, count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill6();
    ntests++;
    if (count !== 3'd6 || full !== 1'b1) begin
      nfail++;
      $display("FAIL fill6: count=%0d full=%b, want 6/1", count, full);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    ntests++;
    if (stomp !== 8'h38 || busy !== 1'b1 || count !== 3'd3 ||
        sns[3] !== 6'h3F || sns[2] !== 6'd2 || live !== 6'b000111) begin
      nfail++;
      $display("FAIL flush: stomp=%h busy=%b count=%0d sns=%h live=%b, want 38/1/3 live=000111",
               stomp, busy, count, sns, live);
    end
    cycle(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    ntests++;
    if (stomp !== 8'h00 || busy !== 1'b0 || count !== 3'd3) begin
      nfail++;
      $display("FAIL flush_after: stomp=%h busy=%b count=%0d, want 00/0/3 (alloc in STOMP dropped)",
               stomp, busy, count);
    end
  endtask

  task automatic test_full_retire_alloc();
    do_reset();
    fill6();
    cycle(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    ntests++;
    if (count !== 3'd6 || sns[0] !== 6'd5 || sns[1] !== 6'd0 || full !== 1'b1) begin
      nfail++;
      $display("FAIL full_retire_alloc: count=%0d sns0=%0d sns1=%0d full=%b, want 6/5/0/1",
               count, sns[0], sns[1], full);
    end
    cycle(1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    ntests++;
    if (count !== 3'd6 || sns[6] !== 6'h3F) begin
      nfail++;
      $display("FAIL alloc_when_full: count=%0d sns6=%h, want 6/3F", count, sns[6]);
    end
  endtask

  task automatic test_random();
    logic [7:0][5:0] exp;
    logic [5:0] exp_live;
    bit r0, r1, fv, a0, a1;
    int idx;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      r0 = (q.size() >= 1) && ($urandom % 3 == 0);
      r1 = r0 && (q.size() >= 2) && ($urandom % 2 == 0);
      fv = ($urandom % 7 == 0);
      a0 = ($urandom % 3 != 0);
      a1 = a0 && ($urandom % 2 == 0);
      cycle(a0, $urandom % 8, a1, $urandom % 8,
            r0, r0 ? q[0] : 0, r1, r1 ? q[1] : 0, fv, $urandom % 8);
      for (int s = 0; s < 8; s++) begin
        idx = find(s);
        exp[s] = (idx < 0) ? 6'h3F : 6'(idx);
        if (s < 6) exp_live[s] = (idx >= 0);
      end
      ntests++;
      if (sns !== exp || live !== exp_live) begin
        nfail++;
        $display("FAIL rand_sns[%0d]: sns=%h live=%b, want sns=%h live=%b",
                 n, sns, live, exp, exp_live);
      end
      ntests++;
      if (count !== 3'(q.size()) || full !== (q.size() == 6)) begin
        nfail++;
        $display("FAIL rand_count[%0d]: count=%0d full=%b, want %0d", n, count, full, q.size());
      end
      ntests++;
      if (stomp !== stomp_m || busy !== busy_m) begin
        nfail++;
        $display("FAIL rand_stomp[%0d]: stomp=%h busy=%b, want %h %b",
                 n, stomp, busy, stomp_m, busy_m);
      end
`ifndef THOR_SEQNUM_CHECK_EN
      ntests++;
      if (err !== 1'b0) begin
        nfail++;
        $display("FAIL rand_err[%0d]: err=%b, want 0", n, err);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_stomp();
    do_reset();
    fill6();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    ntests++;
    if (busy !== 1'b1 || stomp !== 8'h3C) begin
      nfail++;
      $display("FAIL stomp_pre_rst: busy=%b stomp=%h, want 1/3C", busy, stomp);
    end
    rst = 1'b1;
    #1;
    ntests++;
    if (sns !== {8{6'h3F}} || live !== 6'd0 || stomp !== 8'd0 ||
        count !== 3'd0 || busy !== 1'b0 || full !== 1'b0 || err !== 1'b0) begin
      nfail++;
      $display("FAIL async_rst: sns=%h live=%b stomp=%h count=%0d busy=%b, want reset values",
               sns, live, stomp, count, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    busy_m = 0;
    cycle(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    ntests++;
    if (busy !== 1'b0 || count !== 3'd1 || sns[3] !== 6'd0) begin
      nfail++;
      $display("FAIL post_rst_idle: busy=%b count=%0d sns3=%0d, want 0/1/0", busy, count, sns[3]);
    end
  endtask

`ifdef THOR_SEQNUM_CHECK_EN
  task automatic test_err();
    do_reset();
    cycle(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    ntests++;
    if (err !== 1'b0) begin
      nfail++;
      $display("FAIL err_clean: err=%b, want 0", err);
    end
    cycle(0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    ntests++;
    if (err !== 1'b1) begin
      nfail++;
      $display("FAIL err_set: err=%b, want 1", err);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ntests++;
    if (err !== 1'b1) begin
      nfail++;
      $display("FAIL err_sticky: err=%b, want 1", err);
    end
    do_reset();
    ntests++;
    if (err !== 1'b0) begin
      nfail++;
      $display("FAIL err_rst: err=%b, want 0", err);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    busy_m = 0;
    stomp_m = '0;
    test_reset();
    test_alloc();
    test_retire_alloc();
    test_flush();
    test_full_retire_alloc();
    test_random();
    test_reset_mid_stomp();
`ifdef THOR_SEQNUM_CHECK_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
